// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch queue: the default queue depth,
// the instruction/address width and the layout of one queue entry.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_DEPTH_DEFAULT = 2;
    localparam int INST_WIDTH          = 32;

    // One queue slot: fetch address, returned instruction word, fill flag.
    typedef struct packed {
        logic [INST_WIDTH-1:0] addr;
        logic [INST_WIDTH-1:0] data;
        logic                  filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_ram.sv
// ---------------------------------------------------------------------------
// fetch_entry_ram
// DEPTH x fetch_entry_t storage for the fetch queue.
//   clk, reset_n      : clock, synchronous active-low reset (clears fill flags)
//   clear             : synchronous clear of all fill flags (redirect)
//   alloc_en/idx/addr : write port 1 - record fetch address, mark unfilled
//   fill_en/idx/data  : write port 2 - record instruction word, mark filled
//   rd_idx / rd_entry : asynchronous read port (head of queue)
// ---------------------------------------------------------------------------
module fetch_entry_ram
    import fetch_pkg::*;
#(
    parameter int  DEPTH = FETCH_DEPTH_DEFAULT,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  alloc_en,
    input  logic [IDX_W-1:0]      alloc_idx,
    input  logic [INST_WIDTH-1:0] alloc_addr,
    input  logic                  fill_en,
    input  logic [IDX_W-1:0]      fill_idx,
    input  logic [INST_WIDTH-1:0] fill_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output fetch_entry_t          rd_entry
);

    fetch_entry_t mem_r [DEPTH];

    // Entry writes; alloc and fill never target the same slot in one cycle
    // because a full queue blocks allocation.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_en) begin
                mem_r[alloc_idx].addr   <= alloc_addr;
                mem_r[alloc_idx].filled <= 1'b0;
            end
            if (fill_en) begin
                mem_r[fill_idx].data   <= fill_data;
                mem_r[fill_idx].filled <= 1'b1;
            end
        end
    end

    assign rd_entry = mem_r[rd_idx];

endmodule

// File: rtl/instr_fetch_queue_checker.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_checker
// Protocol checks for instr_fetch_queue.
//   clk, reset_n    : clock, synchronous active-low reset
//   imem_resp_valid : memory read data valid
//   outstanding     : requests issued and not yet answered (incl. dropped)
// ---------------------------------------------------------------------------
module instr_fetch_queue_checker #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset_n,
    input logic             imem_resp_valid,
    input logic [CNT_W-1:0] outstanding
);

    // Every response must answer an earlier accepted request.
    a_resp_has_request: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_resp_valid |-> (outstanding != {CNT_W{1'b0}})
    );

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// In-order instruction fetch queue between the PC register, instruction
// memory and decode. Slots are allocated when a request is accepted, filled
// when the (in-order) response returns and freed when decode consumes them.
// A flush empties the queue and counts in-flight responses to be discarded.
//   clk, reset_n          : clock, synchronous active-low reset
//   pc / pc_enable        : fetch address in, PC advance out
//   flush                 : redirect, discard queued and in-flight fetches
//   imem_req_*            : memory request (valid/ready/addr)
//   imem_resp_*           : memory response (valid/data, no backpressure)
//   inst_valid/ready/data/pc : head instruction to decode
// DATA_WIDTH must equal fetch_pkg::INST_WIDTH.
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH      = FETCH_DEPTH_DEFAULT,
    parameter int DATA_WIDTH = INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_enable,
    input  logic                  flush,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   DEPTH_W  = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] fill_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] drop_cnt_r;

    logic [PTR_W-1:0] alloc_count_s;
    logic [PTR_W-1:0] in_flight_s;
    logic [PTR_W-1:0] resp_one_s;
    logic [PTR_W:0]   occupancy_s;
    logic [PTR_W:0]   outstanding_s;
    logic             accept_s;
    logic             fill_s;
    logic             drop_s;
    logic             consume_s;
    fetch_entry_t     head_s;

    assign alloc_count_s = wr_ptr_r - rd_ptr_r;
    assign in_flight_s   = wr_ptr_r - fill_ptr_r;
    assign resp_one_s    = {{(PTR_W-1){1'b0}}, imem_resp_valid};
    // Slots still owed to stale responses count against capacity so a
    // post-flush fill can never land on a slot a stale response targets.
    assign occupancy_s   = {1'b0, alloc_count_s} + {1'b0, drop_cnt_r};
    assign outstanding_s = {1'b0, in_flight_s} + {1'b0, drop_cnt_r};

    assign imem_req_valid = !flush && (occupancy_s < DEPTH_W);
    assign imem_req_addr  = pc;
    assign accept_s       = imem_req_valid && imem_req_ready;
    assign pc_enable      = accept_s;

    assign drop_s    = imem_resp_valid && (drop_cnt_r != PTR_ZERO);
    assign fill_s    = imem_resp_valid && (drop_cnt_r == PTR_ZERO) && !flush;

    assign inst_valid = (wr_ptr_r != rd_ptr_r) && head_s.filled;
    assign inst_data  = head_s.data;
    assign inst_pc    = head_s.addr;
    // Flush wins over a same-cycle consumption.
    assign consume_s  = inst_valid && inst_ready && !flush;

    // Pointer and drop-count state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r   <= PTR_ZERO;
            fill_ptr_r <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            drop_cnt_r <= PTR_ZERO;
        end else if (flush) begin
            wr_ptr_r   <= PTR_ZERO;
            fill_ptr_r <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            // Everything still in flight becomes stale; any response arriving
            // now (dropped or not) is already discarded this cycle.
            drop_cnt_r <= drop_cnt_r + in_flight_s - resp_one_s;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (fill_s) begin
                fill_ptr_r <= fill_ptr_r + PTR_ONE;
            end
            if (consume_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                drop_cnt_r <= drop_cnt_r - PTR_ONE;
            end
        end
    end

    fetch_entry_ram #(
        .DEPTH (DEPTH)
    ) u_entry_ram (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (flush),
        .alloc_en   (accept_s),
        .alloc_idx  (wr_ptr_r[IDX_W-1:0]),
        .alloc_addr (pc),
        .fill_en    (fill_s),
        .fill_idx   (fill_ptr_r[IDX_W-1:0]),
        .fill_data  (imem_resp_data),
        .rd_idx     (rd_ptr_r[IDX_W-1:0]),
        .rd_entry   (head_s)
    );

    instr_fetch_queue_checker #(
        .CNT_W (PTR_W+1)
    ) u_checker (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_resp_valid (imem_resp_valid),
        .outstanding     (outstanding_s)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed table of per-cycle vectors against a DEPTH=2 queue, followed by
// back-to-back and random-ready sequences against a DEPTH=4 queue driven by a
// one-cycle memory model.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DEPTH=2 instance signals
    logic        a_rst_n, a_flush, a_pc_enable, a_req_valid, a_req_ready;
    logic        a_resp_valid, a_inst_valid, a_inst_ready;
    logic [31:0] a_pc, a_req_addr, a_resp_data, a_inst_data, a_inst_pc;

    // DEPTH=4 instance signals
    logic        b_rst_n, b_flush, b_pc_enable, b_req_valid, b_req_ready;
    logic        b_resp_valid, b_inst_valid, b_inst_ready;
    logic [31:0] b_pc, b_req_addr, b_resp_data, b_inst_data, b_inst_pc;

    instr_fetch_queue #(.DEPTH(2), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .reset_n(a_rst_n), .pc(a_pc), .pc_enable(a_pc_enable),
        .flush(a_flush), .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready),
        .imem_req_addr(a_req_addr), .imem_resp_valid(a_resp_valid),
        .imem_resp_data(a_resp_data), .inst_valid(a_inst_valid),
        .inst_ready(a_inst_ready), .inst_data(a_inst_data), .inst_pc(a_inst_pc)
    );

    instr_fetch_queue #(.DEPTH(4), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .reset_n(b_rst_n), .pc(b_pc), .pc_enable(b_pc_enable),
        .flush(b_flush), .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready),
        .imem_req_addr(b_req_addr), .imem_resp_valid(b_resp_valid),
        .imem_resp_data(b_resp_data), .inst_valid(b_inst_valid),
        .inst_ready(b_inst_ready), .inst_data(b_inst_data), .inst_pc(b_inst_pc)
    );

    typedef struct {
        logic        rst_n, flush;
        logic [31:0] pc;
        logic        req_ready, resp_valid;
        logic [31:0] resp_data;
        logic        inst_ready;
        logic        chk_req, exp_req_valid, exp_pc_enable;
        logic [31:0] exp_addr;
        logic        chk_inst, exp_inst_valid;
        logic [31:0] exp_inst_pc, exp_inst_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add_v(input logic rst_n, input logic flush, input logic [31:0] pc,
                         input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic ir, input logic chk_req, input logic erv,
                         input logic epe, input logic [31:0] eaddr, input logic chk_inst,
                         input logic eiv, input logic [31:0] epc, input logic [31:0] edata);
        vec_t v;
        v.rst_n = rst_n; v.flush = flush; v.pc = pc; v.req_ready = rdy;
        v.resp_valid = rv; v.resp_data = rdata; v.inst_ready = ir;
        v.chk_req = chk_req; v.exp_req_valid = erv; v.exp_pc_enable = epe;
        v.exp_addr = eaddr; v.chk_inst = chk_inst; v.exp_inst_valid = eiv;
        v.exp_inst_pc = epc; v.exp_inst_data = edata;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // DEPTH=4 memory/decode model state
    logic        b_pend_v;
    logic [31:0] b_pend_addr;
    logic [31:0] b_exp_pc;
    int          b_alloc, b_filled, b_consumed;

    // One cycle on the DEPTH=4 queue: one-cycle memory, decode always ready.
    task automatic b_cycle(input logic rdy, input int idx);
        logic exp_rv, exp_iv, acc, con;
        b_req_ready  = rdy;
        b_resp_valid = b_pend_v;
        b_resp_data  = mem_word(b_pend_addr);
        @(negedge clk);
        exp_rv = (b_alloc < 4);
        exp_iv = (b_filled > b_consumed);
        check($sformatf("b_req_valid[%0d]", idx), {31'd0, b_req_valid}, {31'd0, exp_rv});
        check($sformatf("b_pc_enable[%0d]", idx), {31'd0, b_pc_enable}, {31'd0, exp_rv && rdy});
        check($sformatf("b_req_addr[%0d]", idx), b_req_addr, b_pc);
        check($sformatf("b_inst_valid[%0d]", idx), {31'd0, b_inst_valid}, {31'd0, exp_iv});
        if (exp_iv) begin
            check($sformatf("b_inst_pc[%0d]", idx), b_inst_pc, b_exp_pc);
            check($sformatf("b_inst_data[%0d]", idx), b_inst_data, mem_word(b_exp_pc));
        end
        acc = exp_rv && rdy;
        con = exp_iv;
        @(posedge clk);
        #1;
        if (b_pend_v) b_filled++;
        b_pend_v    = acc;
        b_pend_addr = b_pc;
        if (acc) begin
            b_pc = b_pc + 32'd4;
            b_alloc++;
        end
        if (con) begin
            b_exp_pc = b_exp_pc + 32'd4;
            b_consumed++;
            b_alloc--;
        end
    endtask

    initial begin
        vec_t v;
        int   consumed_start;

        //     rst flush pc            rdy rv rdata          ir | chk rv pe addr        | chk iv pc            data
        add_v(0, 0, 32'h0,         1, 0, 32'h0,          0,  0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h0,         1, 0, 32'h0,          1,  1, 1, 1, 32'h0,        1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h4,         1, 1, 32'h13,         1,  1, 1, 1, 32'h4,        1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h8,         1, 1, 32'h13,         1,  1, 0, 0, 32'h8,        1, 1, 32'h0,   32'h13);
        add_v(1, 0, 32'h8,         1, 0, 32'h0,          1,  1, 1, 1, 32'h8,        1, 1, 32'h4,   32'h13);
        add_v(1, 0, 32'hC,         1, 1, 32'h11111111,   0,  1, 1, 1, 32'hC,        1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h10,        1, 1, 32'h22222222,   0,  1, 0, 0, 32'h10,       1, 1, 32'h8,   32'h11111111);
        add_v(1, 0, 32'h10,        1, 0, 32'h0,          0,  1, 0, 0, 32'h10,       1, 1, 32'h8,   32'h11111111);
        add_v(1, 0, 32'h10,        1, 0, 32'h0,          1,  1, 0, 0, 32'h10,       1, 1, 32'h8,   32'h11111111);
        add_v(1, 0, 32'h10,        1, 0, 32'h0,          0,  1, 1, 1, 32'h10,       1, 1, 32'hC,   32'h22222222);
        add_v(1, 0, 32'h14,        0, 0, 32'h0,          1,  1, 0, 0, 32'h14,       1, 1, 32'hC,   32'h22222222);
        add_v(1, 0, 32'h14,        0, 1, 32'h33333333,   1,  1, 1, 0, 32'h14,       1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h14,        1, 0, 32'h0,          0,  1, 1, 1, 32'h14,       1, 1, 32'h10,  32'h33333333);
        add_v(1, 0, 32'h18,        1, 0, 32'h0,          1,  1, 0, 0, 32'h18,       1, 1, 32'h10,  32'h33333333);
        add_v(1, 0, 32'h18,        1, 0, 32'h0,          0,  1, 1, 1, 32'h18,       1, 0, 32'h0,   32'h0);
        // flush with two requests in flight, then two stale responses
        add_v(1, 1, 32'h100,       1, 0, 32'h0,          1,  1, 0, 0, 32'h100,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h100,       1, 1, 32'hDEAD0014,   1,  1, 0, 0, 32'h100,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h100,       1, 1, 32'hDEAD0018,   1,  1, 1, 1, 32'h100,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h104,       0, 1, 32'hCAFE0100,   1,  1, 1, 0, 32'h104,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h104,       0, 0, 32'h0,          1,  1, 1, 0, 32'h104,      1, 1, 32'h100, 32'hCAFE0100);
        add_v(1, 0, 32'h104,       1, 0, 32'h0,          1,  1, 1, 1, 32'h104,      1, 0, 32'h0,   32'h0);
        // flush coinciding with a non-dropped response
        add_v(1, 1, 32'h200,       1, 1, 32'hBAD00104,   1,  1, 0, 0, 32'h200,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h200,       1, 0, 32'h0,          1,  1, 1, 1, 32'h200,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h204,       0, 1, 32'h00000200,   0,  1, 1, 0, 32'h204,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h204,       0, 0, 32'h0,          0,  1, 1, 0, 32'h204,      1, 1, 32'h200, 32'h00000200);
        // flush with a valid head being consumed: the consumption is ignored
        add_v(1, 1, 32'h300,       1, 0, 32'h0,          1,  1, 0, 0, 32'h300,      1, 1, 32'h200, 32'h00000200);
        add_v(1, 0, 32'h300,       1, 0, 32'h0,          1,  1, 1, 1, 32'h300,      1, 0, 32'h0,   32'h0);
        // one-cycle reset mid-stream, fetch restarts from the current pc
        add_v(0, 0, 32'h304,       1, 0, 32'h0,          0,  0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h304,       1, 0, 32'h0,          0,  1, 1, 1, 32'h304,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h308,       0, 1, 32'h0304BEEF,   0,  1, 1, 0, 32'h308,      1, 0, 32'h0,   32'h0);
        add_v(1, 0, 32'h308,       0, 0, 32'h0,          1,  1, 1, 0, 32'h308,      1, 1, 32'h304, 32'h0304BEEF);
        add_v(1, 0, 32'h308,       0, 0, 32'h0,          0,  1, 1, 0, 32'h308,      1, 0, 32'h0,   32'h0);

        b_rst_n = 1'b0; b_flush = 1'b0; b_pc = 32'h1000; b_req_ready = 1'b0;
        b_resp_valid = 1'b0; b_resp_data = 32'h0; b_inst_ready = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            a_rst_n = v.rst_n; a_flush = v.flush; a_pc = v.pc; a_req_ready = v.req_ready;
            a_resp_valid = v.resp_valid; a_resp_data = v.resp_data; a_inst_ready = v.inst_ready;
            @(negedge clk);
            if (v.chk_req) begin
                check($sformatf("a_req_valid[%0d]", i), {31'd0, a_req_valid}, {31'd0, v.exp_req_valid});
                check($sformatf("a_pc_enable[%0d]", i), {31'd0, a_pc_enable}, {31'd0, v.exp_pc_enable});
                check($sformatf("a_req_addr[%0d]", i), a_req_addr, v.exp_addr);
            end
            if (v.chk_inst) begin
                check($sformatf("a_inst_valid[%0d]", i), {31'd0, a_inst_valid}, {31'd0, v.exp_inst_valid});
                if (v.exp_inst_valid) begin
                    check($sformatf("a_inst_pc[%0d]", i), a_inst_pc, v.exp_inst_pc);
                    check($sformatf("a_inst_data[%0d]", i), a_inst_data, v.exp_inst_data);
                end
            end
            @(posedge clk);
            #1;
        end
        a_req_ready = 1'b0; a_resp_valid = 1'b0; a_inst_ready = 1'b0;

        // DEPTH=4: back-to-back request/response/consume, then random ready
        b_rst_n = 1'b1;
        b_pend_v = 1'b0; b_pend_addr = 32'h0; b_exp_pc = 32'h1000;
        b_alloc = 0; b_filled = 0; b_consumed = 0;
        for (int c = 0; c < 22; c++) begin
            b_cycle(1'b1, c);
        end
        check("b_throughput", b_consumed, 32'd20);

        consumed_start = b_consumed;
        for (int c = 0; c < 40; c++) begin
            b_cycle(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, 100 + c);
        end
        for (int c = 0; c < 6; c++) begin
            b_cycle(1'b0, 200 + c);
        end
        check("b_drained_empty", {31'd0, b_inst_valid}, 32'd0);
        check("b_random_in_order", b_exp_pc, b_pc);
        if (b_consumed == consumed_start) begin
            check("b_random_progress", b_consumed, consumed_start + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, 2, number of queue entries (power of 2, >=2); DATA_WIDTH, 32, instruction and address width.
REQ-002 Ports SHALL be, in order:
  clk  in  1  sole clock, rising edge
  reset_n  in  1  synchronous active-low reset
  pc  in  32  current fetch address from the PC register
  pc_enable  out  1  advance PC (drives the PC register enable)
  flush  in  1  redirect: discard all queued and in-flight fetches
  imem_req_valid  out  1  memory read request valid
  imem_req_ready  in  1  memory accepts request
  imem_req_addr  out  32  request address
  imem_resp_valid  in  1  read data valid (in order, no backpressure)
  imem_resp_data  in  32  read data
  inst_valid  out  1  head instruction available to decode
  inst_ready  in  1  decode accepts head instruction
  inst_data  out  32  head instruction word
  inst_pc  out  32  address of head instruction
REQ-003 The block SHALL use one clock domain (clk) and a synchronous, active-low reset (reset_n).

Function
REQ-004 Entries SHALL be allocated at request acceptance, filled at response and freed at consumption, using write (alloc), fill and read pointers of log2(DEPTH)+1 bits with wrap-around.
REQ-005 alloc_count = wr_ptr - rd_ptr; drop_cnt = number of in-flight responses still to be discarded.
REQ-006 imem_req_valid SHALL equal !flush && (alloc_count + drop_cnt < DEPTH); it is combinational from registered state and flush.
REQ-007 imem_req_addr SHALL equal pc, held stable while imem_req_valid && !imem_req_ready.
REQ-008 pc_enable SHALL equal imem_req_valid && imem_req_ready; on that cycle the entry at wr_ptr SHALL record pc, be marked unfilled, and wr_ptr SHALL increment.
REQ-009 With imem_resp_valid and drop_cnt>0, the response SHALL be discarded and drop_cnt decremented.
REQ-010 With imem_resp_valid and drop_cnt==0, imem_resp_data SHALL be written to the entry at fill_ptr, marked filled, and fill_ptr incremented.
REQ-011 A response with no outstanding request is a protocol error; behaviour is undefined, and an assertion SHALL flag it.
REQ-012 inst_valid SHALL be 1 when the entry at rd_ptr is allocated and filled; inst_data and inst_pc SHALL come from that entry (registered storage, mux only).
REQ-013 Minimum latency SHALL be: response at cycle N -> inst_valid at cycle N+1.
REQ-014 inst_valid && inst_ready SHALL free the head and increment rd_ptr; inst_valid SHALL NOT drop while inst_ready is low, except on flush or reset.
REQ-015 Request acceptance, response fill and consumption SHALL all be legal in the same cycle, with independent pointer updates.
REQ-016 On flush, at the next edge: wr/fill/rd pointers SHALL reset to 0, all entries SHALL become invalid, and drop_cnt SHALL become (drop_cnt + wr_ptr - fill_ptr) minus 1 if a non-dropped response arrives in the flush cycle (that response is discarded).
REQ-017 Flush SHALL take priority over a consumption in the same cycle; the consumption is ignored.
REQ-018 With DEPTH entries allocated, no request SHALL issue until a slot frees; a slot freed in cycle N SHALL permit a request in cycle N+1.

Reset
REQ-019 While reset_n==0 at a rising edge, all pointers, drop_cnt and entry valid/filled bits SHALL clear to 0.
REQ-020 Outputs after reset SHALL be: inst_valid=0, imem_req_valid=1 (unless flush=1), pc_enable=imem_req_ready; inst_data/inst_pc don't-care.
REQ-021 Reset mid-operation SHALL abandon in-flight requests without drop tracking; the memory shall be reset together with this block.

Structure
REQ-022 A shared package fetch_pkg SHALL hold FETCH_DEPTH_DEFAULT, INST_WIDTH and the entry struct typedef {addr, data, filled}.
REQ-023 Entry storage SHALL be a single sub-module, fetch_entry_ram (DEPTH x entry, one write port for alloc, one for fill, one async read).

Verification
REQ-024 Reset then imem_req_ready=1 with 1-cycle memory returning 0x00000013: requests at pc=0x0, 0x4 -> inst_pc 0x0, then 0x4, each instruction one cycle after its response.
REQ-025 inst_ready=0 with DEPTH=2: exactly 2 requests accepted, then imem_req_valid=0 and pc_enable=0; one consume -> one new request on the next cycle.
REQ-026 Flush with 2 requests in flight: no inst_valid from the 2 stale responses (drop_cnt 2->0); the first post-flush response is returned with its new pc.
REQ-027 Simultaneous request, response and consume for 20 back-to-back cycles: throughput of 1 instruction per cycle, with pc order preserved.
REQ-028 imem_req_ready toggling randomly: imem_req_addr stays stable while stalled, and pc_enable pulses once per accepted request.
REQ-029 reset_n low mid-stream for 1 cycle: the next cycle shows inst_valid=0, pointers 0, and a fetch restarting from the current pc.
